// File: rtl/robot_pkg.sv
// Shared encodings for the maze robot: move commands, navigation FSM states and
// sensor bit positions, common to the navigation controller and the map memory.
package robot_pkg;

  typedef enum logic [1:0] {
    CMD_FWD    = 2'd0,
    CMD_TURN_L = 2'd1,
    CMD_TURN_R = 2'd2,
    CMD_REMOVE = 2'd3
  } cmd_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SENSE  = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_STUCK  = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int SNS_HEAD    = 0;
  localparam int SNS_LEFT    = 1;
  localparam int SNS_UNDER   = 2;
  localparam int SNS_BARRIER = 3;
  localparam int SNS_W       = 4;

  typedef logic [SNS_W-1:0] sensors_t;

endpackage

// File: rtl/robot_decide.sv
// Left-hand wall-following rule: maps registered sensors plus the "last move was
// TURN_L" flag to the next move command and an exit-reached flag. Purely combinational.
module robot_decide
  import robot_pkg::*;
(
  input  sensors_t   sns,
  input  logic       jl,
  output logic [1:0] op,
  output logic       exit_hit
);

  // jl stops a second left turn in a row when the wall is still missing after turning.
  always_comb begin
    exit_hit = sns[SNS_UNDER];
    op       = CMD_TURN_R;
    if (!sns[SNS_LEFT] && !jl)
      op = CMD_TURN_L;
    else if (!sns[SNS_HEAD])
      op = CMD_FWD;
    else if (sns[SNS_BARRIER])
      op = CMD_REMOVE;
  end

endmodule

// File: rtl/robot_nav_ctrl.sv
// Maze robot navigation FSM: sense, decide, issue one move over valid/ack, repeat.
// Optional forward-step budget enabled by defining STEP_LIMIT_EN.
module robot_nav_ctrl
  import robot_pkg::*;
#(
  parameter int STEP_W      = 10,
  parameter int MAX_STEPS   = 1000,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sense_valid,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  input  logic              cmd_ack,
  output logic              done,
  output logic              stuck,
  output logic              error,
  output logic [STEP_W-1:0] step_count
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

`ifdef STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic [2:0]        state;
  sensors_t          sns_q;
  logic              sv_q;
  logic              jl;
  logic [2:0]        turn_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        dec_op;
  logic              dec_exit;
  logic [STEP_W-1:0] step_inc;
  logic [2:0]        turn_inc;
  logic              is_turn;
  logic              limit_hit;

  robot_decide u_decide (
    .sns      (sns_q),
    .jl       (jl),
    .op       (dec_op),
    .exit_hit (dec_exit)
  );

  assign step_inc  = (&step_count) ? step_count : step_count + STEP_W'(1);
  assign turn_inc  = turn_cnt + 3'd1;
  assign is_turn   = (cmd_op == CMD_TURN_L) || (cmd_op == CMD_TURN_R);
  assign limit_hit = LIMIT_EN && (step_inc == STEP_W'(MAX_STEPS));

  assign cmd_valid = (state == ST_ISSUE);
  assign done      = (state == ST_DONE);
  assign stuck     = (state == ST_STUCK);
  assign error     = (state == ST_ERROR);

  // Sensors are captured in SENSE and only acted upon one cycle later (sv_q), so the
  // command appears two edges after the sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sns_q      <= '0;
      sv_q       <= 1'b0;
      jl         <= 1'b0;
      turn_cnt   <= 3'd0;
      to_cnt     <= '0;
      cmd_op     <= CMD_FWD;
      step_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sv_q  <= 1'b0;
          state <= ST_SENSE;
        end
        ST_SENSE: begin
          if (sv_q) begin
            sv_q  <= 1'b0;
            state <= ST_DECIDE;
          end else if (sense_valid) begin
            sns_q[SNS_HEAD]    <= head;
            sns_q[SNS_LEFT]    <= left;
            sns_q[SNS_UNDER]   <= under;
            sns_q[SNS_BARRIER] <= barrier;
            sv_q               <= 1'b1;
          end
        end
        ST_DECIDE: begin
          if (dec_exit) begin
            state <= ST_DONE;
          end else begin
            cmd_op <= dec_op;
            to_cnt <= '0;
            state  <= ST_ISSUE;
          end
        end
        // An ack on the final timeout cycle still completes the transfer.
        ST_ISSUE: begin
          if (cmd_ack) begin
            jl       <= (cmd_op == CMD_TURN_L);
            turn_cnt <= is_turn ? turn_inc : 3'd0;
            if (cmd_op == CMD_FWD)
              step_count <= step_inc;
            if (is_turn && (turn_inc == 3'd4))
              state <= ST_STUCK;
            else if ((cmd_op == CMD_FWD) && limit_hit)
              state <= ST_STUCK;
            else
              state <= ST_SENSE;
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            state <= ST_ERROR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// Scoreboard bench for robot_nav_ctrl: directed sensor vectors push the expected move,
// a negedge monitor pops and compares on every accepted transfer.
module tb_robot_nav_ctrl;
  import robot_pkg::*;

  localparam int STEP_W      = 3;
  localparam int MAX_STEPS   = 3;
  localparam int ACK_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sense_valid = 1'b0;
  logic              head = 1'b0;
  logic              left = 1'b0;
  logic              under = 1'b0;
  logic              barrier = 1'b0;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ack = 1'b0;
  logic              done;
  logic              stuck;
  logic              error;
  logic [STEP_W-1:0] step_count;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  robot_nav_ctrl #(
    .STEP_W      (STEP_W),
    .MAX_STEPS   (MAX_STEPS),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sense_valid (sense_valid),
    .head        (head),
    .left        (left),
    .under       (under),
    .barrier     (barrier),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ack     (cmd_ack),
    .done        (done),
    .stuck       (stuck),
    .error       (error),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    sense_valid = 1'b0;
    cmd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_cmd_op", cmd_op, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_stuck", stuck, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_step_count", step_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ack_delay < 0 means never acknowledge and expect the timeout error.
  task automatic applyStimulus(input bit h, input bit l, input bit u, input bit b,
                               input logic [1:0] exp_op, input int ack_delay);
    int n;
    head = h; left = l; under = u; barrier = b;
    sense_valid = 1'b1;
    @(posedge clk);
    #1;
    sense_valid = 1'b0;
    if (u) begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("exit_done", done, 1);
      checkOutput("exit_no_cmd", cmd_valid, 0);
      return;
    end
    n = 0;
    while (!cmd_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("cmd_latency", n, 2);
    if (!cmd_valid) return;
    if (ack_delay < 0) begin
      repeat (ACK_TIMEOUT - 1) @(posedge clk);
      #1;
      checkOutput("pre_timeout_error", error, 0);
      checkOutput("pre_timeout_valid", cmd_valid, 1);
      @(posedge clk);
      #1;
      checkOutput("timeout_error", error, 1);
      checkOutput("timeout_valid", cmd_valid, 0);
      return;
    end
    exp_q.push_back(exp_op);
    repeat (ack_delay) begin
      @(posedge clk);
      #1;
    end
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    cmd_ack = 1'b0;
    checkOutput("cmd_valid_drop", cmd_valid, 0);
  endtask

  // Monitor: each accepted transfer must match the oldest expected move.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cmd_valid && cmd_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_transfer: got op %0d expected none", cmd_op);
        end else begin
          checkOutput("cmd_op", int'(cmd_op), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Basic wall following: turn left, jl suppresses second left, remove, forward.
    doReset();
    applyStimulus(0, 0, 0, 0, CMD_TURN_L, 0);
    applyStimulus(0, 0, 0, 0, CMD_FWD, 1);
    checkOutput("step_after_fwd", step_count, 1);
    applyStimulus(1, 1, 0, 1, CMD_REMOVE, 0);
    applyStimulus(0, 1, 0, 0, CMD_FWD, 2);
    checkOutput("step_after_fwd2", step_count, 2);
    applyStimulus(0, 0, 0, 0, CMD_TURN_L, 0);
    checkOutput("s1_stuck", stuck, 0);

    // Turn guard: REMOVE and FWD clear the count, four turns in a row get stuck.
    doReset();
    applyStimulus(1, 0, 0, 0, CMD_TURN_L, 0);
    applyStimulus(1, 0, 0, 0, CMD_TURN_R, 0);
    applyStimulus(1, 1, 0, 0, CMD_TURN_R, 0);
    applyStimulus(1, 1, 0, 1, CMD_REMOVE, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, CMD_TURN_R, 0);
    checkOutput("guard_after_remove", stuck, 0);
    applyStimulus(0, 1, 0, 0, CMD_FWD, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, CMD_TURN_R, 0);
    checkOutput("guard_after_fwd", stuck, 0);
    applyStimulus(1, 1, 0, 0, CMD_TURN_R, 0);
    checkOutput("guard_stuck", stuck, 1);
    sense_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sense_valid = 1'b0;
    checkOutput("stuck_no_cmd", cmd_valid, 0);
    checkOutput("stuck_sticky", stuck, 1);

    // Ack timeout: ack on the last allowed cycle wins, no ack at all gives error.
    doReset();
    applyStimulus(0, 1, 0, 0, CMD_FWD, ACK_TIMEOUT - 1);
    checkOutput("late_ack_step", step_count, 1);
    checkOutput("late_ack_error", error, 0);
    applyStimulus(0, 1, 0, 0, CMD_FWD, -1);
    cmd_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmd_ack = 1'b0;
    checkOutput("ack_ignored_step", step_count, 1);
    checkOutput("error_sticky", error, 1);

    // Exit cell takes priority over a missing left wall.
    doReset();
    applyStimulus(0, 0, 1, 0, CMD_FWD, 0);
    checkOutput("done_no_stuck", stuck, 0);
    checkOutput("done_no_error", error, 0);

    // Forward steps: budget with STEP_LIMIT_EN, plain saturation otherwise.
    doReset();
`ifdef STEP_LIMIT_EN
    for (int i = 0; i < MAX_STEPS; i++) begin
      applyStimulus(0, 1, 0, 0, CMD_FWD, 0);
      checkOutput("limit_step", step_count, i + 1);
      checkOutput("limit_stuck", stuck, (i == MAX_STEPS - 1) ? 1 : 0);
    end
`else
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, 0, CMD_FWD, 0);
      checkOutput("sat_step", step_count, (i + 1 > 7) ? 7 : i + 1);
    end
    checkOutput("sat_stuck", stuck, 0);
`endif

    repeat (2) @(posedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
